tl_demux: RTL and testbench
===========================

Name: tl_demux

Overview:
- 1:N response/route demultiplexer for the TileLink crossbar; the mirror of the N:1 request arbiter.
- Accepts one message stream and steers each message to one of N sinks, selected by a destination field carried in the beat.
- Multi-beat messages stay locked to the destination decoded from their first beat.
- One registered output stage gives 1-cycle latency at full throughput. Out-of-range destinations are consumed, dropped and flagged.

Parameters:
- N, 4, number of output sinks (2..16)
- DATA_W, 100, beat width in bits
- SEL_LSB, 0, bit position of the destination field within data_i
- SEL_W, 2, width of the destination field; requires 2^SEL_W >= N and SEL_LSB+SEL_W <= DATA_W

Ports:
- clk  in  1  clock; one clock for the whole block
- rst  in  1  reset; reset is synchronous and active-high
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i && ready_o
- data_i  in  DATA_W  input beat; destination = data_i[SEL_LSB +: SEL_W]
- last_i  in  1  1 = last (or only) beat of message, 0 = more beats follow
- valid_o  out  N  per-sink valid; at most one bit set
- ready_i  in  N  per-sink ready
- data_o  out  N*DATA_W  registered beat, replicated on every lane; only the lane with valid_o set is meaningful
- last_o  out  N  per-lane last flag, qualified by valid_o
- err_o  out  1  one-cycle pulse: first beat of a message with destination >= N was accepted

Behaviour:
- Output register contents: out_vld_q, out_dst_q, out_data_q, out_last_q.
  - valid_o[d] = out_vld_q && (out_dst_q == d).
  - last_o[d] = valid_o[d] && out_last_q.
  - Every data_o lane = out_data_q.
- ready_o is combinational: ready_o = !out_vld_q || ready_i[out_dst_q], except in the DROP state, where ready_o = 1.
- Register update on each clk:
  - Accepted routed beat: load the register; out_vld_q = 1.
  - Sink handshake with no new beat: out_vld_q = 0.
  - Both in the same cycle: load the new beat (back-to-back, no bubble).
- Latency: an accepted beat appears on valid_o in the next cycle. Sustained throughput is 1 beat/cycle while the target sink holds ready.
- Route FSM:
  - IDLE, beat accepted with dst < N:
    - last_i = 1: route to dst, stay IDLE.
    - last_i = 0: route to dst, capture lock_dst_q = dst, go to BURST.
  - IDLE, beat accepted with dst >= N:
    - Beat is dropped (not loaded into the register); err_o = 1 in the following cycle.
    - last_i = 0: go to DROP. last_i = 1: stay IDLE.
  - BURST:
    - Each accepted beat is routed to lock_dst_q. The sel field of non-first beats is ignored, even if out of range.
    - Accepted beat with last_i = 1: go to IDLE.
  - DROP:
    - Beats are consumed with ready_o = 1 and discarded. No further err_o pulses.
    - Accepted beat with last_i = 1: go to IDLE.
- The destination is evaluated only on the first beat, i.e. in IDLE.
- In DROP, a beat still held in the output register continues to drain independently.
- A dropped beat never blocks: it is accepted even if the output register is full and stalled.
- Reset values: out_vld_q = 0, so valid_o = 0 and last_o = 0; err_o = 0; FSM = IDLE; lock_dst_q = 0; out_data_q = 0.
- ready_o in reset cycles is don't-care; it must be 1 in the first post-reset cycle.
- Reset mid-burst: the lock is lost and the held beat is discarded. The next accepted beat is treated as a first beat.
- Handshake rules:
  - valid_o and out_data_q must hold stable until ready_i[out_dst_q] is seen.
  - ready_i on non-selected lanes is ignored.
  - valid_o never depends combinationally on ready_i.

Test Plan:
- Single-beat routing, N = 4: beats with dst 2, 0, 3 and last_i = 1, all ready_i high -> valid_o = 0100, 0001, 1000 on consecutive cycles, each 1 cycle after acceptance; data_o matches; ready_o held at 1.
- Burst lock: a 4-beat message with dst = 1 on beat 0 and garbage dst (3, 0, 2) on beats 1-3 -> all four beats appear on lane 1 with last_o[1] only on the fourth. The next message with dst = 3 goes to lane 3.
- Backpressure: ready_i[2] = 0 for 5 cycles while out_vld_q is set for lane 2 -> ready_o = 0, data_o stable for all 5 cycles. Raising ready_i[0] during this time has no effect. After ready_i[2] rises, the next beat follows with no bubble.
- Out-of-range with N = 3, SEL_W = 2: a 3-beat message with dst = 3 -> ready_o = 1 for all beats, no valid_o asserted, err_o high for exactly 1 cycle. The following message with dst = 0 is routed normally.
- Drop while stalled: the register holds a beat for lane 1 with ready_i[1] = 0, and a single-beat dst = 3 message arrives -> it is accepted immediately and err_o pulses. The lane-1 beat is preserved and delivered once ready_i[1] = 1.
- Reset mid-burst: rst asserted after beat 2 of a 4-beat dst = 2 burst -> valid_o = 0 and FSM = IDLE after reset. A post-reset beat with dst = 0 and last_i = 1 goes to lane 0.

Source files
------------

// File: rtl/tl_demux_if.sv
// Handshake bundle between the message source, tl_demux and its N sinks.
// The slave modport is the demux side; the master modport is the source/sink side.
interface tl_demux_if #(
  parameter int N      = 4,
  parameter int DATA_W = 100
);
  logic                valid_i;
  logic                ready_o;
  logic [DATA_W-1:0]   data_i;
  logic                last_i;
  logic [N-1:0]        valid_o;
  logic [N-1:0]        ready_i;
  logic [N*DATA_W-1:0] data_o;
  logic [N-1:0]        last_o;
  logic                err_o;

  modport slave (
    input  valid_i, data_i, last_i, ready_i,
    output ready_o, valid_o, data_o, last_o, err_o
  );

  modport master (
    output valid_i, data_i, last_i, ready_i,
    input  ready_o, valid_o, data_o, last_o, err_o
  );
endinterface

// File: rtl/tl_demux.sv
// 1:N message demultiplexer: the first beat's destination field picks a sink,
// later beats follow it; out-of-range messages are swallowed and flagged once.
module tl_demux #(
  parameter int N       = 4,
  parameter int DATA_W  = 100,
  parameter int SEL_LSB = 0,
  parameter int SEL_W   = 2
) (
  input  logic      clk,
  input  logic      rst,
  tl_demux_if.slave bus
);
  localparam int LANES = 2 ** SEL_W;
  localparam logic [SEL_W:0] N_W = (SEL_W + 1)'(N);

  typedef enum logic [1:0] {IDLE, BURST, DROP} state_t;

  state_t            state_reg;
  logic              out_vld_reg;
  logic [SEL_W-1:0]  out_dst_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_last_reg;
  logic [SEL_W-1:0]  lock_dst_reg;
  logic              err_reg;

  logic [LANES-1:0]  ready_pad;
  logic [SEL_W-1:0]  sel_dst;
  logic [SEL_W-1:0]  route_dst;
  logic              in_range;
  logic              drop_beat;
  logic              sink_ready;
  logic              accept;
  logic              load;

  // Zero-padded so the held destination can index it without range issues.
  always_comb begin
    ready_pad        = '0;
    ready_pad[N-1:0] = bus.ready_i;
  end

  assign sel_dst    = bus.data_i[SEL_LSB +: SEL_W];
  assign in_range   = {1'b0, sel_dst} < N_W;
  // Dropped beats bypass the output register, so they never wait on a stalled sink.
  assign drop_beat  = (state_reg == DROP) || ((state_reg == IDLE) && !in_range);
  assign sink_ready = ready_pad[out_dst_reg];
  assign bus.ready_o = drop_beat || !out_vld_reg || sink_ready;
  assign accept     = bus.valid_i && bus.ready_o;
  assign load       = accept && !drop_beat;
  assign route_dst  = (state_reg == BURST) ? lock_dst_reg : sel_dst;
  assign bus.err_o  = err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      out_vld_reg  <= 1'b0;
      out_dst_reg  <= '0;
      out_data_reg <= '0;
      out_last_reg <= 1'b0;
      lock_dst_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      err_reg <= accept && (state_reg == IDLE) && !in_range;

      if (load) begin
        out_vld_reg  <= 1'b1;
        out_dst_reg  <= route_dst;
        out_data_reg <= bus.data_i;
        out_last_reg <= bus.last_i;
      end else if (out_vld_reg && sink_ready) begin
        out_vld_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (accept && !bus.last_i) begin
            if (in_range) begin
              state_reg    <= BURST;
              lock_dst_reg <= sel_dst;
            end else begin
              state_reg <= DROP;
            end
          end
        end
        BURST, DROP: begin
          if (accept && bus.last_i) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      localparam logic [SEL_W-1:0] LANE = SEL_W'(gi);
      assign bus.valid_o[gi]                  = out_vld_reg && (out_dst_reg == LANE);
      assign bus.last_o[gi]                   = out_vld_reg && (out_dst_reg == LANE) && out_last_reg;
      assign bus.data_o[gi*DATA_W +: DATA_W]  = out_data_reg;
    end
  endgenerate
endmodule

// File: tb/tb_tl_demux.sv
// Bench for tl_demux: a 4-sink instance for routing/locking/backpressure and a
// 3-sink instance for out-of-range dropping; delivered beats are scoreboarded.
module tb_tl_demux;
  localparam int DW = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tl_demux_if #(.N(4), .DATA_W(DW)) b4 ();
  tl_demux_if #(.N(3), .DATA_W(DW)) b3 ();

  tl_demux #(.N(4), .DATA_W(DW), .SEL_LSB(0), .SEL_W(2)) u4 (
    .clk(clk), .rst(rst), .bus(b4)
  );
  tl_demux #(.N(3), .DATA_W(DW), .SEL_LSB(0), .SEL_W(2)) u3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  typedef struct {
    int          lane;
    logic [DW-1:0] data;
    logic        last;
  } exp_t;

  exp_t exp4[$];
  exp_t exp3[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   err3_cnt = 0;

  function automatic logic [DW-1:0] mk(input int dst);
    logic [DW-1:0] d;
    d         = '0;
    d[31:0]   = $urandom;
    d[63:32]  = $urandom;
    d[95:64]  = $urandom;
    d[99:96]  = 4'($urandom);
    d[1:0]    = 2'(dst);
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [DW-1:0] d, input logic l, input int lane, output int waited);
    logic ok;
    b4.valid_i = 1'b1;
    b4.data_i  = d;
    b4.last_i  = l;
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (b4.ready_o === 1'b1) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL send4_timeout: ready_o stayed %b, required 1", b4.ready_o);
    end else if (lane >= 0) begin
      exp4.push_back('{lane: lane, data: d, last: l});
    end
    step();
  endtask

  task automatic send3(input logic [DW-1:0] d, input logic l, input int lane, output int waited);
    logic ok;
    b3.valid_i = 1'b1;
    b3.data_i  = d;
    b3.last_i  = l;
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (b3.ready_o === 1'b1) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL send3_timeout: ready_o stayed %b, required 1", b3.ready_o);
    end else if (lane >= 0) begin
      exp3.push_back('{lane: lane, data: d, last: l});
    end
    step();
  endtask

  task automatic test_reset();
    b4.valid_i = 1'b0; b4.data_i = '0; b4.last_i = 1'b0; b4.ready_i = '0;
    b3.valid_i = 1'b0; b3.data_i = '0; b3.last_i = 1'b0; b3.ready_i = '0;
    rst = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (b4.valid_o !== 4'b0 || b4.last_o !== 4'b0 || b4.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out4: valid_o=%b last_o=%b err_o=%b, required 0/0/0", b4.valid_o, b4.last_o, b4.err_o);
    end
    n_cmp++;
    if (b4.data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data4: data_o nonzero %h, required 0", b4.data_o);
    end
    n_cmp++;
    if (b3.valid_o !== 3'b0 || b3.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out3: valid_o=%b err_o=%b, required 0/0", b3.valid_o, b3.err_o);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b4.ready_o !== 1'b1 || b3.ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: ready_o=%b/%b, required 1/1", b4.ready_o, b3.ready_o);
    end
    step();
    $display("test_reset done");
  endtask

  task automatic test_single();
    int dsts [3] = '{2, 0, 3};
    int w;
    b4.ready_i = 4'b1111;
    foreach (dsts[i]) begin
      send4(mk(dsts[i]), 1'b1, dsts[i], w);
      n_cmp++;
      if (w !== 0 || b4.valid_o !== 4'(1 << dsts[i])) begin
        n_fail++;
        $display("FAIL single_route: wait=%0d valid_o=%b, required wait=0 valid_o=%b", w, b4.valid_o, 4'(1 << dsts[i]));
      end
      $display("single beat dst=%0d valid_o=%b", dsts[i], b4.valid_o);
    end
    b4.valid_i = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_burst_lock();
    int sel [4] = '{1, 3, 0, 2};
    int w;
    b4.ready_i = 4'b1111;
    foreach (sel[i]) begin
      send4(mk(sel[i]), (i == 3), 1, w);
      n_cmp++;
      if (b4.valid_o !== 4'b0010 || b4.last_o !== ((i == 3) ? 4'b0010 : 4'b0000)) begin
        n_fail++;
        $display("FAIL burst_beat%0d: valid_o=%b last_o=%b, required 0010/%b", i, b4.valid_o, b4.last_o, (i == 3) ? 4'b0010 : 4'b0000);
      end
      $display("burst beat %0d sel=%0d valid_o=%b last_o=%b", i, sel[i], b4.valid_o, b4.last_o);
    end
    send4(mk(3), 1'b1, 3, w);
    n_cmp++;
    if (b4.valid_o !== 4'b1000) begin
      n_fail++;
      $display("FAIL burst_next: valid_o=%b, required 1000", b4.valid_o);
    end
    b4.valid_i = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b;
    int w;
    a = mk(2);
    b = mk(1);
    b4.ready_i = 4'b0000;
    send4(a, 1'b1, 2, w);
    b4.valid_i = 1'b1; b4.data_i = b; b4.last_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (b4.ready_o !== 1'b0 || b4.valid_o !== 4'b0100 || b4.data_o[2*DW +: DW] !== a) begin
        n_fail++;
        $display("FAIL bp_hold%0d: ready_o=%b valid_o=%b data=%h, required 0/0100/%h", i, b4.ready_o, b4.valid_o, b4.data_o[2*DW +: DW], a);
      end
      step();
      if (i == 1) b4.ready_i[0] = 1'b1;
    end
    b4.ready_i = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if (b4.ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: ready_o=%b, required 1", b4.ready_o);
    end else begin
      exp4.push_back('{lane: 1, data: b, last: 1'b1});
    end
    step();
    b4.valid_i = 1'b0;
    n_cmp++;
    if (b4.valid_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_no_bubble: valid_o=%b, required 0010", b4.valid_o);
    end
    $display("backpressure released, next valid_o=%b", b4.valid_o);
    repeat (2) step();
  endtask

  task automatic test_drop();
    int sel [3] = '{3, 0, 2};
    int w;
    b3.ready_i = 3'b111;
    err3_cnt = 0;
    foreach (sel[i]) begin
      send3(mk(sel[i]), (i == 2), -1, w);
      n_cmp++;
      if (w !== 0 || b3.valid_o !== 3'b000 || b3.err_o !== (i == 0)) begin
        n_fail++;
        $display("FAIL drop_beat%0d: wait=%0d valid_o=%b err_o=%b, required 0/000/%b", i, w, b3.valid_o, b3.err_o, (i == 0));
      end
      $display("drop beat %0d sel=%0d valid_o=%b err_o=%b", i, sel[i], b3.valid_o, b3.err_o);
    end
    send3(mk(0), 1'b1, 0, w);
    b3.valid_i = 1'b0;
    n_cmp++;
    if (b3.valid_o !== 3'b001) begin
      n_fail++;
      $display("FAIL drop_next: valid_o=%b, required 001", b3.valid_o);
    end
    repeat (3) step();
    n_cmp++;
    if (err3_cnt !== 1) begin
      n_fail++;
      $display("FAIL drop_err_count: err pulses=%0d, required 1", err3_cnt);
    end
  endtask

  task automatic test_drop_stalled();
    logic [DW-1:0] a;
    int w;
    a = mk(1);
    b3.ready_i = 3'b000;
    err3_cnt = 0;
    send3(a, 1'b1, 1, w);
    send3(mk(3), 1'b1, -1, w);
    b3.valid_i = 1'b0;
    n_cmp++;
    if (w !== 0 || b3.err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_drop_accept: wait=%0d err_o=%b, required 0/1", w, b3.err_o);
    end
    repeat (2) step();
    n_cmp++;
    if (b3.valid_o !== 3'b010 || b3.data_o[1*DW +: DW] !== a) begin
      n_fail++;
      $display("FAIL stall_hold: valid_o=%b data=%h, required 010/%h", b3.valid_o, b3.data_o[1*DW +: DW], a);
    end
    b3.ready_i = 3'b111;
    repeat (3) step();
    n_cmp++;
    if (err3_cnt !== 1 || b3.valid_o !== 3'b000) begin
      n_fail++;
      $display("FAIL stall_after: err pulses=%0d valid_o=%b, required 1/000", err3_cnt, b3.valid_o);
    end
    $display("drop while stalled: err pulses=%0d", err3_cnt);
  endtask

  task automatic test_reset_mid_burst();
    int w;
    b4.ready_i = 4'b1111;
    send4(mk(2), 1'b0, 2, w);
    send4(mk(1), 1'b0, 2, w);
    b4.valid_i = 1'b0;
    b4.ready_i = 4'b0000;
    rst = 1'b1;
    // The held second beat is lost to reset, so it is never expected.
    if (exp4.size() > 0) void'(exp4.pop_back());
    step();
    n_cmp++;
    if (b4.valid_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_clear: valid_o=%b, required 0000", b4.valid_o);
    end
    step();
    rst = 1'b0;
    b4.ready_i = 4'b1111;
    send4(mk(0), 1'b1, 0, w);
    b4.valid_i = 1'b0;
    n_cmp++;
    if (b4.valid_o !== 4'b0001 || b4.last_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL midrst_first: valid_o=%b last_o=%b, required 0001/0001", b4.valid_o, b4.last_o);
    end
    $display("post-reset beat valid_o=%b", b4.valid_o);
    repeat (2) step();
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          exp_t e;
          int   lane;
          if (b3.err_o === 1'b1) err3_cnt++;
          n_cmp++;
          if ($countones(b4.valid_o) > 1 || $countones(b3.valid_o) > 1 || b4.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL onehot: valid_o4=%b valid_o3=%b err_o4=%b, required <=1 bit and err_o4=0", b4.valid_o, b3.valid_o, b4.err_o);
          end
          lane = -1;
          for (int i = 0; i < 4; i++) if (b4.valid_o[i]) lane = i;
          if (lane >= 0 && b4.ready_i[lane]) begin
            n_cmp++;
            if (exp4.size() == 0) begin
              n_fail++;
              $display("FAIL sb4_unexpected: lane=%0d data=%h, required no beat", lane, b4.data_o[lane*DW +: DW]);
            end else begin
              e = exp4.pop_front();
              if (lane !== e.lane || b4.data_o[lane*DW +: DW] !== e.data || b4.last_o[lane] !== e.last) begin
                n_fail++;
                $display("FAIL sb4_beat: lane=%0d last=%b data=%h, required lane=%0d last=%b data=%h", lane, b4.last_o[lane], b4.data_o[lane*DW +: DW], e.lane, e.last, e.data);
              end
              $display("sink4 lane=%0d last=%b data=%h", lane, b4.last_o[lane], b4.data_o[lane*DW +: DW]);
            end
          end
          lane = -1;
          for (int i = 0; i < 3; i++) if (b3.valid_o[i]) lane = i;
          if (lane >= 0 && b3.ready_i[lane]) begin
            n_cmp++;
            if (exp3.size() == 0) begin
              n_fail++;
              $display("FAIL sb3_unexpected: lane=%0d data=%h, required no beat", lane, b3.data_o[lane*DW +: DW]);
            end else begin
              e = exp3.pop_front();
              if (lane !== e.lane || b3.data_o[lane*DW +: DW] !== e.data || b3.last_o[lane] !== e.last) begin
                n_fail++;
                $display("FAIL sb3_beat: lane=%0d last=%b data=%h, required lane=%0d last=%b data=%h", lane, b3.last_o[lane], b3.data_o[lane*DW +: DW], e.lane, e.last, e.data);
              end
              $display("sink3 lane=%0d last=%b data=%h", lane, b3.last_o[lane], b3.data_o[lane*DW +: DW]);
            end
          end
        end
      end
    join_none

    test_reset();
    test_single();
    test_burst_lock();
    test_backpressure();
    test_drop();
    test_drop_stalled();
    test_reset_mid_burst();

    for (int i = 0; i < 20 && (exp4.size() + exp3.size()) > 0; i++) step();
    n_cmp++;
    if (exp4.size() != 0 || exp3.size() != 0) begin
      n_fail++;
      $display("FAIL drain: undelivered beats %0d/%0d, required 0/0", exp4.size(), exp3.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
